// File: rtl/divisor_seq_ctrl.sv
// Sequencer for the 16-bit shift/restore divider datapath.
// It accepts a START request and checks for a zero divisor.
// For each quotient bit it issues one SH cycle followed by one TEST cycle.
// In the TEST cycle it issues either LDA or QSH, chosen by the sign (MSB)
// of the trial subtraction, which the datapath computes.
// When the last bit is done, it pulses DONE for one cycle.
module divisor_seq_ctrl #(
   parameter int WIDTH = 16,  // operand width, also the iteration count
   parameter int CNT_W = 5    // iteration counter width, 2**CNT_W > WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] DIVISOR,
   input  logic             MSB,
   output logic             INIT,
   output logic             SH,
   output logic             LDA,
   output logic             QSH,
   output logic             Q_BIT,
   output logic             BUSY,
   output logic             DONE,
   output logic             DZ_ERR,
   output logic [CNT_W-1:0] ITER
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_TEST,
      S_DONE_ST,
      S_ERR
   } state_e;

   localparam logic [CNT_W-1:0] ITER_LOAD = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] ITER_ONE  = CNT_W'(1);

   state_e           state_q;
   logic             init_q;
   logic             sh_q;
   logic             test_q;
   logic             done_q;
   logic             busy_q;
   logic             dz_err_q;
   logic [CNT_W-1:0] iter_q;

   // State register, iteration counter and registered Moore strobes.
   // The Moore strobes are computed from the state being entered, so each
   // one is high exactly while the FSM sits in the matching state.
   // NOTE: all state uses non-blocking assignments. Reset is synchronous
   // and covers only this controller; the datapath keeps its contents.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         init_q   <= 1'b0;
         sh_q     <= 1'b0;
         test_q   <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         dz_err_q <= 1'b0;
         iter_q   <= '0;
      end else begin
         init_q <= 1'b0;
         sh_q   <= 1'b0;
         test_q <= 1'b0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (START) begin
                  if (DIVISOR != '0) begin
                     state_q  <= S_LOAD;
                     init_q   <= 1'b1;
                     busy_q   <= 1'b1;
                     dz_err_q <= 1'b0;
                  end else begin
                     state_q  <= S_ERR;
                     done_q   <= 1'b1;
                     dz_err_q <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               state_q <= S_SHIFT;
               sh_q    <= 1'b1;
               busy_q  <= 1'b1;
               iter_q  <= ITER_LOAD;
            end
            S_SHIFT: begin
               state_q <= S_TEST;
               test_q  <= 1'b1;
               busy_q  <= 1'b1;
            end
            S_TEST: begin
               iter_q <= iter_q - ITER_ONE;
               busy_q <= 1'b1;
               if (iter_q == ITER_ONE) begin
                  state_q <= S_DONE_ST;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= S_SHIFT;
                  sh_q    <= 1'b1;
               end
            end
            S_DONE_ST: state_q <= S_IDLE;
            S_ERR:     state_q <= S_IDLE;
            default:   state_q <= S_IDLE;
         endcase
      end
   end

   // In TEST, MSB arrives combinationally from the subtractor and selects
   // LDA or QSH.
   // NOTE: these are plain continuous assigns with no storage, so no
   // latch can be inferred.
   assign LDA    = test_q & ~MSB;
   assign QSH    = test_q & MSB;
   assign Q_BIT  = test_q & ~MSB;

   assign INIT   = init_q;
   assign SH     = sh_q;
   assign BUSY   = busy_q;
   assign DONE   = done_q;
   assign DZ_ERR = dz_err_q;
   assign ITER   = iter_q;

endmodule

// File: doc/divisor_seq_ctrl.md
Name: divisor_seq_ctrl

Overview:
FSM controller that sequences the 16-bit shift/restore divider datapath inside the calculator's divisor core. It accepts a START request, checks for a zero divisor, and drives the datapath strobes: INIT, SH, LDA and QSH. It runs one shift/test pair per quotient bit and reports completion with a one-cycle DONE pulse. The arithmetic itself lives in the shift register and adder; this block only decides what happens on each cycle.

Parameters:
WIDTH, 16, operand width; equals the number of iterations.
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous reset, active-high
START  in  1  request a division; sampled only in IDLE
DIVISOR  in  WIDTH  divisor operand, used only for the zero check at START
MSB  in  1  sign bit of the trial subtraction (A - divisor); 1 means negative, so no load
INIT  out  1  datapath load/clear strobe
SH  out  1  shift {A,DV} left by one
LDA  out  1  load A with the subtractor result and shift quotient bit 1 into R
QSH  out  1  shift quotient bit 0 into R without loading A
Q_BIT  out  1  quotient bit for this iteration (1 when LDA, 0 when QSH)
BUSY  out  1  high from the LOAD state through the DONE state
DONE  out  1  one-cycle completion pulse, also pulsed on error
DZ_ERR  out  1  divide-by-zero flag; stays high until the next accepted START
ITER  out  CNT_W  number of iterations remaining (debug)

Behaviour:
- Reset: state=IDLE. INIT, SH, LDA, QSH, Q_BIT, BUSY, DONE and DZ_ERR are 0. ITER=0.
- RST has priority over every other input, including START in the same cycle.
- A reset mid-operation returns the FSM to IDLE at the next edge and drops all strobes. Datapath contents are left as they are.
- Strobe outputs are Moore-decoded from state. Exception: LDA, QSH and Q_BIT in TEST are decoded from state plus MSB, which the datapath provides combinationally.
- At most one of INIT, SH, LDA, QSH is high in any cycle.
- States:
  - IDLE: all strobes 0, BUSY=0.
    - START=1 and DIVISOR!=0 → LOAD. Clear DZ_ERR.
    - START=1 and DIVISOR==0 → ERR.
  - LOAD: INIT=1, BUSY=1. ITER<=WIDTH. Next state SHIFT.
  - SHIFT: SH=1, BUSY=1. Next state TEST.
  - TEST: BUSY=1. ITER<=ITER-1.
    - MSB=0 → LDA=1, Q_BIT=1.
    - MSB=1 → QSH=1, Q_BIT=0.
    - Next state: DONE_ST if ITER==1 before the decrement, else SHIFT.
  - DONE_ST: DONE=1, BUSY=1. Next state IDLE.
  - ERR: DONE=1, DZ_ERR<=1, BUSY=0, no INIT. Next state IDLE.
- Latency: START sampled in cycle c.
  - LOAD in c+1.
  - Iterations occupy c+2 through c+2*WIDTH+1.
  - DONE in c+2*WIDTH+2, which is c+34 for WIDTH=16.
  - IDLE in c+35.
- Error latency: DONE and DZ_ERR both appear in c+1.
- START outside IDLE is ignored; no queueing.
- START held high through DONE_ST is accepted again in the following IDLE cycle (back-to-back operation).
- ITER never wraps; it reaches 0 exactly on entry to DONE_ST and stays 0 until the next LOAD.
- The quotient is complete in R and the remainder in A when DONE rises.
- DIVISOR is not re-sampled after LOAD, so changes mid-operation have no effect on the controller.

Test Plan:
- Reset then idle: hold RST 3 cycles, then START=0 for 10 cycles → every output 0, BUSY=0.
- 100/7: START with DIVISOR=7, MSB driven by a reference datapath model.
  - Exactly 1 INIT, 16 SH, 3 LDA, 13 QSH.
  - Q_BIT sequence 0000000000001110.
  - DONE in cycle c+34; R=14, A=2.
- Divide by zero: START with DIVISOR=0.
  - DONE=1 and DZ_ERR=1 in c+1; no INIT/SH/LDA.
  - DZ_ERR stays 1 until a later START with DIVISOR=5, then clears in that LOAD cycle.
- START pulses while busy: extra START at cycles c+5 and c+20 of a 65535/1 operation.
  - Single operation only, DONE at c+34.
  - R=65535, 16 LDA.
- Reset mid-operation: assert RST at iteration 8 (cycle c+17).
  - IDLE and all strobes 0 in c+18.
  - A new START at c+20 runs a full 34-cycle sequence.
- Back-to-back: START held high for 80 cycles with DIVISOR=3.
  - Two complete operations; second LOAD exactly 2 cycles after the first DONE.
  - Strobes never overlap.
